// File: rtl/ttl_func_sweeper.sv
// Programmable N-input truth table with serial reload and a self-test sweep; E is registered, 1 clock after X.
// No backpressure: LD_EN/START are sampled only in IDLE and dropped otherwise; BUSY flags LOAD and SWEEP.
module ttl_func_sweeper #(
  parameter int                   N    = 4,
  parameter logic [(1<<N)-1:0]    INIT = 16'h0C1E
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [N-1:0] X,
  input  logic         LD_EN,
  input  logic         LD_BIT,
  input  logic         START,
  output logic         E,
  output logic         BUSY,
  output logic         DONE,
  output logic [N:0]   ONES
);

  localparam int W = 1 << N;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SWEEP = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t         state;
  state_t         nxt;
  logic [W-1:0]   tbl;
  logic [N-1:0]   cnt;
  logic           cnt_last;
  logic           busy_nxt;
  logic           done_nxt;

  assign cnt_last = (cnt == {N{1'b1}});

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= nxt;
      BUSY  <= busy_nxt;
      DONE  <= done_nxt;
    end
  end

  // LD_EN takes priority over START; both are ignored outside IDLE.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (LD_EN)      nxt = S_LOAD;
        else if (START) nxt = S_SWEEP;
      end
      S_LOAD:  if (cnt_last) nxt = S_IDLE;
      S_SWEEP: if (cnt_last) nxt = S_FIN;
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // BUSY/DONE are decoded from the next state so the registered flags line up with the state register.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (nxt)
      S_LOAD, S_SWEEP: busy_nxt = 1'b1;
      S_FIN:           done_nxt = 1'b1;
      default: begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tbl  <= INIT;
      cnt  <= '0;
      E    <= 1'b0;
      ONES <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          E   <= tbl[X];
          cnt <= '0;
          if (!LD_EN && START) ONES <= '0;
        end
        S_LOAD: begin
          tbl <= {tbl[W-2:0], LD_BIT};
          if (!cnt_last) cnt <= cnt + N'(1);
        end
        S_SWEEP: begin
          E    <= tbl[cnt];
          ONES <= ONES + (N+1)'(tbl[cnt]);
          if (!cnt_last) cnt <= cnt + N'(1);
        end
        S_FIN: begin
          E <= tbl[X];
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ttl_func_sweeper.sv
// Scoreboarded random bench for ttl_func_sweeper: N=4 default table and N=3 majority table instances.
// Driver pushes cycle-tagged expectations from a table model; a negedge monitor pops and compares.
module tb_ttl_func_sweeper;

  logic       clk;
  logic       rst_n;
  logic [3:0] x4;
  logic       ld4, bit4, st4;
  logic       e4, busy4, done4;
  logic [4:0] ones4;
  logic [2:0] x3;
  logic       ld3, bit3, st3;
  logic       e3, busy3, done3;
  logic [3:0] ones3;

  ttl_func_sweeper dut4 (
    .CLK(clk), .RST_N(rst_n), .X(x4), .LD_EN(ld4), .LD_BIT(bit4), .START(st4),
    .E(e4), .BUSY(busy4), .DONE(done4), .ONES(ones4)
  );

  ttl_func_sweeper #(.N(3), .INIT(8'hE8)) dut3 (
    .CLK(clk), .RST_N(rst_n), .X(x3), .LD_EN(ld3), .LD_BIT(bit3), .START(st3),
    .E(e3), .BUSY(busy3), .DONE(done3), .ONES(ones3)
  );

  typedef struct {
    int    tag;
    int    d;
    logic  e;
    logic  busy;
    logic  done;
    int    ones;
    string nm;
  } rec_t;

  rec_t        sb[$];
  rec_t        r;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  logic [15:0] tbl_m [2];
  int          ones_m [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].tag <= cyc) begin
      r = sb.pop_front();
      if (r.tag != cyc) begin
        chk({r.nm, "_stale_tag"}, r.tag, cyc);
      end else if (r.d == 0) begin
        chk({r.nm, "_e4"},    e4,    r.e);
        chk({r.nm, "_busy4"}, busy4, r.busy);
        chk({r.nm, "_done4"}, done4, r.done);
        chk({r.nm, "_ones4"}, ones4, r.ones);
      end else begin
        chk({r.nm, "_e3"},    e3,    r.e);
        chk({r.nm, "_busy3"}, busy3, r.busy);
        chk({r.nm, "_done3"}, done3, r.done);
        chk({r.nm, "_ones3"}, ones3, r.ones);
      end
    end
  end

  function automatic int wof(input int d);
    return (d == 0) ? 16 : 8;
  endfunction

  task automatic model_reset();
    tbl_m[0]  = 16'h0C1E;
    tbl_m[1]  = 16'h00E8;
    ones_m[0] = 0;
    ones_m[1] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input int x, input bit ld, input bit b, input bit st);
    if (d == 0) begin
      x4 = 4'(x); ld4 = ld; bit4 = b; st4 = st;
      x3 = '0;    ld3 = 1'b0; bit3 = 1'b0; st3 = 1'b0;
    end else begin
      x3 = 3'(x); ld3 = ld; bit3 = b; st3 = st;
      x4 = '0;    ld4 = 1'b0; bit4 = 1'b0; st4 = 1'b0;
    end
  endtask

  // Expectation for the outputs visible after the next rising edge.
  task automatic push(input int d, input logic e, input logic busy, input logic done,
                      input int ones, input string nm);
    rec_t t;
    t.tag = cyc + 1; t.d = d; t.e = e; t.busy = busy; t.done = done; t.ones = ones; t.nm = nm;
    sb.push_back(t);
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_zero(input string nm);
    chk({nm, "_e4"}, e4, 0);    chk({nm, "_busy4"}, busy4, 0);
    chk({nm, "_done4"}, done4, 0); chk({nm, "_ones4"}, ones4, 0);
    chk({nm, "_e3"}, e3, 0);    chk({nm, "_busy3"}, busy3, 0);
    chk({nm, "_done3"}, done3, 0); chk({nm, "_ones3"}, ones3, 0);
  endtask

  // Asserts reset mid-cycle, checks outputs clear without a clock edge, holds across one edge.
  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("async_rst");
    push(0, 1'b0, 1'b0, 1'b0, 0, "rst_hold");
    push(1, 1'b0, 1'b0, 1'b0, 0, "rst_hold");
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic idle_eval(input int d, input int x);
    drive(d, x, 1'b0, rb(), 1'b0);
    push(d, tbl_m[d][x], 1'b0, 1'b0, ones_m[d], "eval");
    tick();
  endtask

  task automatic do_load(input int d, input logic [15:0] v, input bit with_start, input int abort_at);
    int   w;
    int   x;
    logic e_hold;
    w = wof(d);
    x = $urandom_range(0, w - 1);
    drive(d, x, 1'b1, rb(), with_start);
    e_hold = tbl_m[d][x];
    push(d, e_hold, 1'b1, 1'b0, ones_m[d], "ld_req");
    tick();
    for (int j = 0; j < w; j++) begin
      if (j == abort_at) begin
        do_reset();
        return;
      end
      drive(d, $urandom_range(0, w - 1), rb(), v[w-1-j], rb());
      push(d, e_hold, (j < w - 1), 1'b0, ones_m[d], "load");
      tick();
    end
    tbl_m[d] = (d == 0) ? v : {8'h00, v[7:0]};
  endtask

  task automatic do_sweep(input int d, input int abort_at);
    int w;
    int x;
    int running;
    w = wof(d);
    x = $urandom_range(0, w - 1);
    drive(d, x, 1'b0, rb(), 1'b1);
    push(d, tbl_m[d][x], 1'b1, 1'b0, 0, "sw_req");
    ones_m[d] = 0;
    tick();
    running = 0;
    for (int j = 0; j < w; j++) begin
      if (j == abort_at) begin
        do_reset();
        return;
      end
      running += int'(tbl_m[d][j]);
      drive(d, $urandom_range(0, w - 1), rb(), rb(), rb());
      push(d, tbl_m[d][j], (j < w - 1), (j == w - 1), running, "sweep");
      tick();
    end
    ones_m[d] = running;
    x = $urandom_range(0, w - 1);
    drive(d, x, rb(), rb(), rb());
    push(d, tbl_m[d][x], 1'b0, 1'b0, ones_m[d], "fin");
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got running expected finished");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    int d;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst_n = 1'b0;
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;

    idle_eval(0, 1);
    idle_eval(0, 5);
    idle_eval(0, 10);
    idle_eval(0, 15);
    do_sweep(0, -1);
    idle_eval(0, 3);

    do_load(0, 16'h8001, 1'b0, -1);
    idle_eval(0, 15);
    idle_eval(0, 0);
    idle_eval(0, 1);
    do_sweep(0, -1);
    do_load(0, 16'hFFFF, 1'b0, -1);
    do_sweep(0, -1);

    do_load(0, 16'($urandom), 1'b1, -1);
    idle_eval(0, $urandom_range(0, 15));
    idle_eval(0, $urandom_range(0, 15));

    do_load(0, 16'h0000, 1'b0, 7);
    idle_eval(0, 1);
    do_sweep(0, 9);
    idle_eval(0, 1);

    idle_eval(1, 3);
    idle_eval(1, 4);
    do_sweep(1, -1);
    idle_eval(1, 7);

    repeat (40) begin
      d  = $urandom_range(0, 1);
      op = $urandom_range(0, 4);
      case (op)
        0, 1: idle_eval(d, $urandom_range(0, wof(d) - 1));
        2:    do_load(d, 16'($urandom), rb(), -1);
        default: do_sweep(d, -1);
      endcase
    end

    idle_eval(0, $urandom_range(0, 15));
    idle_eval(1, $urandom_range(0, 7));
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
